program_fetch_unit: RTL

- Instruction fetch sequencer that sits directly upstream of program_word_memory.
- Owns the program counter and drives the memory address bus.
- Captures the asynchronously-read instruction word into a registered instruction output with a valid/ready handshake towards the logic execution core.
- Implements the PLC cyclic scan: the END word restarts execution at address 0. A scan watchdog detects runaway programs.

---
 rtl/program_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/program_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives program memory, registers
// the fetched word towards the execute stage, runs the cyclic PLC scan and
// guards each scan with an instruction-count watchdog.
module program_fetch_unit #(
  parameter int              IA_W      = 16,
  parameter int              ID_W      = 24,
  parameter logic [ID_W-1:0] END_WORD  = 24'hFFFFFF,
  parameter int              WDT_LIMIT = 65535
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            STOP,
  output logic [IA_W-1:0] A,
  input  logic [ID_W-1:0] DQ,
  output logic [ID_W-1:0] IR_Q,
  output logic [IA_W-1:0] IR_PC,
  output logic            IR_VALID,
  input  logic            IR_READY,
  input  logic            JMP,
  input  logic [IA_W-1:0] JMP_ADDR,
  output logic            SCAN_DONE,
  output logic [15:0]     SCAN_CNT,
  output logic            BUSY,
  output logic            FAULT
);

  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  state_t           state;
  logic [IA_W-1:0]  pc;
  logic [WDT_W-1:0] wdt;
  logic [WDT_W-1:0] wdt_inc;
  logic             ld;
  logic             is_end;
  logic             wdt_trip;

  assign A        = pc;
  // The IR slot can take a new word when empty or being drained this cycle.
  assign ld       = !IR_VALID || IR_READY;
  assign is_end   = (DQ == END_WORD);
  assign wdt_inc  = wdt + 1'b1;
  // Trip on the issue that would bring the count up to the limit, so at most
  // WDT_LIMIT-1 instructions are issued in one scan.
  assign wdt_trip = (wdt_inc == WDT_W'(WDT_LIMIT));

  // Scan sequencer: state, PC, instruction register, scan counter, watchdog.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pc        <= '0;
      wdt       <= '0;
      IR_Q      <= '0;
      IR_PC     <= '0;
      IR_VALID  <= 1'b0;
      SCAN_DONE <= 1'b0;
      SCAN_CNT  <= '0;
      BUSY      <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      SCAN_DONE <= 1'b0;
      case (state)
        S_IDLE, S_FAULT: begin
          // STOP is meaningless here; only START resumes from address 0.
          if (START) begin
            state <= S_RUN;
            pc    <= '0;
            wdt   <= '0;
            FAULT <= 1'b0;
            BUSY  <= 1'b1;
          end
        end
        S_RUN: begin
          if (STOP) begin
            state    <= S_IDLE;
            IR_VALID <= 1'b0;
            BUSY     <= 1'b0;
          end else if (START) begin
            pc       <= '0;
            wdt      <= '0;
            IR_VALID <= 1'b0;
          end else if (JMP) begin
            // Flush: the word already in IR belongs to the untaken path.
            pc       <= JMP_ADDR;
            IR_VALID <= 1'b0;
          end else if (ld) begin
            if (is_end) begin
              // END word is consumed here and never handed downstream.
              pc        <= '0;
              wdt       <= '0;
              IR_VALID  <= 1'b0;
              SCAN_DONE <= 1'b1;
              SCAN_CNT  <= SCAN_CNT + 16'd1;
            end else if (wdt_trip) begin
              state    <= S_FAULT;
              IR_VALID <= 1'b0;
              BUSY     <= 1'b0;
              FAULT    <= 1'b1;
            end else begin
              IR_Q     <= DQ;
              IR_PC    <= pc;
              IR_VALID <= 1'b1;
              pc       <= pc + 1'b1;
              wdt      <= wdt_inc;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          IR_VALID <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule
